hc595_frame_shifter: RTL and testbench
======================================

// Module: hc595_frame_shifter
// PURPOSE
//  Downstream of the 8-digit hex scanner. Takes its parallel sel[7:0]/seg[7:0] outputs
//  and serialises them into two daisy-chained 74HC595 shift registers on the board.
//  Each frame is a snapshot of {seg,sel}: 16 bits shifted MSB first on SH_CP, then
//  transferred to the 595 outputs with one ST_CP pulse. Frames repeat while en=1.
// PARAMETERS
//  HALF_PERIOD  2   clk cycles per SH_CP/ST_CP half-period, >=1 (50 MHz/(2*2) = 12.5 MHz)
//  FRAME_W      16  bits per frame; fixed at 2x8 by the board, not for user override
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  en          in   1  level; 1 = keep refreshing frames
//  sel         in   8  digit-select word from scanner
//  seg         in   8  segment word from scanner
//  sh_cp       out  1  595 shift clock; 595 samples ds on rising edge
//  st_cp       out  1  595 storage/latch clock
//  ds          out  1  595 serial data
//  busy        out  1  1 from load cycle through end of GAP
//  frame_done  out  1  one-clk pulse as each frame completes
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE; sh_cp=st_cp=ds=busy=frame_done=0;
//   shift reg, bit and half-period counters = 0.
//  Half-period timer: counts 0..HALF_PERIOD-1 in SHIFT/LATCH/GAP; hp_end when count=max.
//   Held at 0 in IDLE.
//  IDLE : outputs low. If en=1: shreg <= {seg,sel}, bit_idx <= 0, phase <= LO, busy <= 1,
//   go to SHIFT. This is the load cycle.
//  SHIFT: ds = shreg[15] at all times.
//   LO phase: sh_cp=0 for HALF_PERIOD clks. HI phase: sh_cp=1 for HALF_PERIOD clks.
//   At hp_end of HI: shreg <= shreg<<1, bit_idx++.
//   After bit 15 HI phase -> LATCH. ds is stable across the whole rising edge.
//  LATCH: sh_cp=0, ds=0, st_cp=1 for HALF_PERIOD clks -> GAP.
//  GAP  : st_cp=0 for HALF_PERIOD clks. At its hp_end: frame_done=1 for 1 clk, busy=0,
//   -> IDLE. If en is still 1, the next load occurs in the following cycle.
//  Frame length (load to return to IDLE) = 34*HALF_PERIOD+1 clks (69 at default).
//  Bit order on the wire: seg[7] first ... seg[0], sel[7] ... sel[0] last.
//   seg[*] lands in the far 595, sel[*] in the near one.
//  sel/seg changes after the load cycle are ignored until the next frame (no tearing).
//  en deasserted mid-frame: the current frame completes, including latch; no new frame.
//  All outputs registered; no combinational input-to-output paths.
// STRUCTURE
//  hc595_pkg: state encoding (IDLE/SHIFT/LATCH/GAP), FRAME_W=16, phase encoding LO/HI.
//  Sub-module hc595_halfper_timer: parameterised HALF_PERIOD counter with clear and
//   hp_end output, clog2-sized. FSM, shift reg and bit counter stay in the top.
// TESTING
//  1. rst=1 mid-SHIFT (bit 7) -> all outputs 0 within same cycle; IDLE after release.
//  2. en=1, seg=8'hC0, sel=8'hFE, HALF_PERIOD=2 -> 595 model holds 16'hC0FE after st_cp
//     rise; frame_done at clk 69 from load.
//  3. Change seg to 8'hF9 at bit 3 of frame -> that frame still latches 16'hC0FE; next
//     frame latches 16'hF9FE.
//  4. Drop en during bit 10 -> frame finishes with exactly one st_cp pulse; then idle,
//     busy=0, no more sh_cp edges.
//  5. HALF_PERIOD=1: 16'hA55A -> 16 sh_cp rises, each 1 clk high; frame = 35 clks.
//  6. Checker on every sh_cp rise: ds unchanged in the clk before and after the edge.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 frame shifter.
// Frame width is fixed by the board (two chained 8-bit 595s).
package hc595_pkg;

    localparam int FRAME_W = 16;
    localparam int BIT_W   = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

endpackage

// File: rtl/hc595_halfper_timer.sv
// Half-period timer: counts 0..HALF_PERIOD-1 while running, flags the last count.
// Held at zero while clr is high so every frame starts on a fresh half-period.
module hc595_halfper_timer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic hp_end
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        hp_end = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            hp_end = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hc595_frame_shifter.sv
// Serialises {seg,sel} into two daisy-chained 74HC595s, MSB first, then pulses ST_CP.
// Frames repeat back to back while en is high; all outputs come straight from flops.
//
//  state | meaning
//  IDLE  | outputs low; load cycle when en=1
//  SHIFT | 16 bits, each LO then HI half-period on sh_cp
//  LATCH | st_cp high for one half-period
//  GAP   | st_cp low for one half-period, then frame_done
module hc595_frame_shifter
    import hc595_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic       sh_cp,
    output logic       st_cp,
    output logic       ds,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    state_e             state_q,   state_d;
    phase_e             phase_q,   phase_d;
    logic [FRAME_W-1:0] shreg_q,   shreg_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic               sh_cp_q,      sh_cp_d;
    logic               st_cp_q,      st_cp_d;
    logic               ds_q,         ds_d;
    logic               busy_q,       busy_d;
    logic               frame_done_q, frame_done_d;

    logic hp_end;

    hc595_halfper_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .hp_end (hp_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_LO;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            sh_cp_q      <= 1'b0;
            st_cp_q      <= 1'b0;
            ds_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            sh_cp_q      <= sh_cp_d;
            st_cp_q      <= st_cp_d;
            ds_q         <= ds_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    shreg_d   = {seg, sel};
                    bit_idx_d = '0;
                    phase_d   = PH_LO;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (hp_end) begin
                    if (phase_q == PH_LO) begin
                        phase_d = PH_HI;
                    end else begin
                        // Data only moves on the falling edge, so ds is stable across the rise.
                        phase_d   = PH_LO;
                        shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = ST_LATCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (hp_end) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (hp_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so the pins are flops, aligned with state.
    always_comb begin
        sh_cp_d      = (state_d == ST_SHIFT) && (phase_d == PH_HI);
        st_cp_d      = (state_d == ST_LATCH);
        ds_d         = (state_d == ST_SHIFT) ? shreg_d[FRAME_W-1] : 1'b0;
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_q == ST_GAP) && hp_end;
    end

    assign sh_cp      = sh_cp_q;
    assign st_cp      = st_cp_q;
    assign ds         = ds_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_frame_shifter.sv
// Bench for hc595_frame_shifter: two instances (HALF_PERIOD 2 and 1) feeding 595 models,
// with a scoreboard of expected latched words and frame_done cycles.
module tb_hc595_frame_shifter;

    typedef struct {
        logic [15:0] data;
        int          fd_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en_w;
    logic [7:0] sel_w [2];
    logic [7:0] seg_w [2];

    logic sh0, st0, ds0, busy0, fd0;
    logic sh1, st1, ds1, busy1, fd1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sh_rise [2];
    int st_rise [2];

    exp_t q0[$];
    exp_t q1[$];

    logic [15:0] sr0 = '0, lat0 = '0, sr1 = '0, lat1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hc595_frame_shifter #(.HALF_PERIOD(2)) u_hp2 (
        .clk(clk), .rst(rst), .en(en_w[0]), .sel(sel_w[0]), .seg(seg_w[0]),
        .sh_cp(sh0), .st_cp(st0), .ds(ds0), .busy(busy0), .frame_done(fd0)
    );

    hc595_frame_shifter #(.HALF_PERIOD(1)) u_hp1 (
        .clk(clk), .rst(rst), .en(en_w[1]), .sel(sel_w[1]), .seg(seg_w[1]),
        .sh_cp(sh1), .st_cp(st1), .ds(ds1), .busy(busy1), .frame_done(fd1)
    );

    // Two chained 74HC595s per instance: shift on sh_cp rise, latch on st_cp rise.
    always @(posedge sh0) sr0 <= {sr0[14:0], ds0};
    always @(posedge st0) lat0 <= sr0;
    always @(posedge sh1) sr1 <= {sr1[14:0], ds1};
    always @(posedge st1) lat1 <= sr1;

    wire [1:0] sh_w   = {sh1, sh0};
    wire [1:0] st_w   = {st1, st0};
    wire [1:0] ds_w   = {ds1, ds0};
    wire [1:0] busy_w = {busy1, busy0};
    wire [1:0] fd_w   = {fd1, fd0};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input logic [15:0] v, input int c);
        exp_t e;
        e.data   = v;
        e.fd_cyc = c;
        q0.push_back(e);
    endtask

    // Monitor: ds stability around sh_cp, high widths, pulse counts, scoreboard pops.
    initial begin
        int   hi_len [2];
        int   hp [2];
        logic sh_p [2];
        logic st_p [2];
        logic ds_p [2];
        logic have;
        exp_t e;
        logic [15:0] lat;
        hp[0] = 2;
        hp[1] = 1;
        for (int d = 0; d < 2; d++) begin
            hi_len[d] = 0; sh_rise[d] = 0; st_rise[d] = 0;
            sh_p[d] = 1'b0; st_p[d] = 1'b0; ds_p[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    sh_rise[d] = 0;
                    st_rise[d] = 0;
                    hi_len[d]  = 0;
                end else begin
                    if (sh_w[d]) begin
                        check($sformatf("ds_stable_hp%0d", hp[d]), ds_w[d], ds_p[d]);
                        hi_len[d]++;
                        if (!sh_p[d]) sh_rise[d]++;
                    end else if (sh_p[d]) begin
                        check($sformatf("sh_hi_len_hp%0d", hp[d]), hi_len[d], hp[d]);
                        hi_len[d] = 0;
                    end
                    if (st_w[d] && !st_p[d]) st_rise[d]++;
                    if (fd_w[d]) begin
                        have = 1'b0;
                        if (d == 0 && q0.size() > 0) begin
                            e = q0.pop_front();
                            have = 1'b1;
                        end else if (d == 1 && q1.size() > 0) begin
                            e = q1.pop_front();
                            have = 1'b1;
                        end
                        lat = (d == 0) ? lat0 : lat1;
                        if (!have) begin
                            check($sformatf("unexpected_frame_hp%0d", hp[d]), 1, 0);
                        end else begin
                            check($sformatf("latched_hp%0d", hp[d]), lat, e.data);
                            check($sformatf("fd_cycle_hp%0d", hp[d]), cyc, e.fd_cyc);
                            check($sformatf("sh_rises_hp%0d", hp[d]), sh_rise[d], 16);
                            check($sformatf("st_pulses_hp%0d", hp[d]), st_rise[d], 1);
                            check($sformatf("busy_at_done_hp%0d", hp[d]), busy_w[d], 0);
                        end
                        sh_rise[d] = 0;
                        st_rise[d] = 0;
                    end
                end
                sh_p[d] = sh_w[d];
                st_p[d] = st_w[d];
                ds_p[d] = ds_w[d];
            end
        end
    end

    // Driver: frame period is 34*HP+1; load edge L gives frame_done visible at cycle L+34*HP.
    initial begin
        int          L;
        int          ln;
        logic [15:0] v;
        exp_t        e;

        rst = 1'b1;
        en_w = 2'b00;
        sel_w[0] = '0; seg_w[0] = '0;
        sel_w[1] = '0; seg_w[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_hp2", {sh0, st0, ds0, busy0, fd0}, 0);
        check("reset_outs_hp1", {sh1, st1, ds1, busy1, fd1}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_en", {sh0, busy0}, 0);

        // Reset in the middle of bit 7.
        seg_w[0] = 8'($urandom);
        sel_w[0] = 8'($urandom);
        en_w[0]  = 1'b1;
        L = cyc + 1;
        wait_cyc(L + 30);
        check("busy_mid_frame", busy0, 1);
        #1 rst = 1'b1;
        #1 check("outs_on_async_rst", {sh0, st0, ds0, busy0, fd0}, 0);
        en_w[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_rst", {sh0, st0, busy0}, 0);

        // Continuous frames, data changed mid-frame must only show in the next frame.
        seg_w[0] = 8'hC0;
        sel_w[0] = 8'hFE;
        en_w[0]  = 1'b1;
        L = cyc + 1;
        push0(16'hC0FE, L + 68);
        wait_cyc(L + 14);
        seg_w[0] = 8'hF9;
        ln = L + 69;
        push0(16'hF9FE, ln + 68);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(ln + int'($urandom_range(1, 68)));
            v = 16'($urandom);
            seg_w[0] = v[15:8];
            sel_w[0] = v[7:0];
            ln = ln + 69;
            push0(v, ln + 68);
        end

        // Drop en during bit 10 of the last frame; it must finish and stop.
        wait_cyc(ln + 42);
        en_w[0]  = 1'b0;
        sel_w[0] = 8'($urandom);
        wait_cyc(ln + 70);
        check("busy_after_stop", busy0, 0);
        wait_cyc(ln + 170);
        check("no_sh_after_stop", sh_rise[0], 0);
        check("no_st_after_stop", st_rise[0], 0);
        check("still_idle", busy0, 0);

        // HALF_PERIOD=1 instance: single frame of 35 clocks.
        seg_w[1] = 8'hA5;
        sel_w[1] = 8'h5A;
        en_w[1]  = 1'b1;
        L = cyc + 1;
        e.data   = 16'hA55A;
        e.fd_cyc = L + 34;
        q1.push_back(e);
        @(posedge clk);
        #1 en_w[1] = 1'b0;
        wait_cyc(L + 45);
        check("hp1_idle_after", busy1, 0);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
